// File: rtl/ifmap_stream_feeder.sv
// Streams a block of ifmap words from the global buffer to one PE over valid/ready.
// Optional IFMAP_FEEDER_ROW_LAST_EN adds a per-word row_last flag carried through the skid buffer.
module ifmap_stream_feeder #(
  parameter int GLOBAL_BUFFER_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH               = 16,
  parameter int IFMAP_SIZE_WIDTH         = 4,
  parameter int N_WIDTH                  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                Start,
  input  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] base_addr,
  input  logic [IFMAP_SIZE_WIDTH-1:0]         ifmap_size,
  input  logic [N_WIDTH-1:0]                  row_count,
  output logic                                gb_rd_en,
  output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] gb_addr,
  input  logic [DATA_WIDTH-1:0]               gb_rdata,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                row_last,
  output logic                                Done
);
  localparam int TW = IFMAP_SIZE_WIDTH + N_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;
  state_t state, state_nxt;

  logic [TW-1:0]         total_in, total_q, issued, sent;
  logic                  in_flight, xfer, wr_ptr, rd_ptr;
  logic [1:0]            cnt, occ;
  logic [DATA_WIDTH-1:0] mem [2];

  assign total_in  = TW'(ifmap_size) * TW'(row_count);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign xfer      = out_valid && out_ready;
  assign occ       = cnt - {1'b0, xfer};
  // Issue only if the word is guaranteed a skid slot when it lands next cycle.
  assign gb_rd_en  = (state == FETCH) && (issued != total_q) &&
                     ((occ + {1'b0, in_flight}) <= 2'd1);
  assign Done      = (state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (Start) state_nxt = (total_in == '0) ? FIN : FETCH;
      FETCH: if (gb_rd_en && (issued + TW'(1) == total_q)) state_nxt = DRAIN;
      DRAIN: if (xfer && (sent + TW'(1) == total_q)) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gb_addr   <= '0;
      total_q   <= '0;
      issued    <= '0;
      sent      <= '0;
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= 2'd0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else begin
      state     <= state_nxt;
      in_flight <= gb_rd_en;
      cnt       <= cnt + {1'b0, in_flight} - {1'b0, xfer};
      if (state == IDLE && Start) begin
        gb_addr <= base_addr;
        total_q <= total_in;
        issued  <= '0;
        sent    <= '0;
      end
      if (gb_rd_en) begin
        gb_addr <= gb_addr + 1'b1;
        issued  <= issued + TW'(1);
      end
      if (in_flight) begin
        mem[wr_ptr] <= gb_rdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr <= ~rd_ptr;
        sent   <= sent + TW'(1);
      end
    end
  end

`ifdef IFMAP_FEEDER_ROW_LAST_EN
  logic [IFMAP_SIZE_WIDTH-1:0] size_q, col;
  logic                        fl_last, issue_last;
  logic                        last_mem [2];

  assign issue_last = (col == size_q - 1'b1);
  assign row_last   = out_valid && last_mem[rd_ptr];

  // Flag is decided at issue time and travels with the word through the skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q      <= '0;
      col         <= '0;
      fl_last     <= 1'b0;
      last_mem[0] <= 1'b0;
      last_mem[1] <= 1'b0;
    end else begin
      fl_last <= gb_rd_en && issue_last;
      if (state == IDLE && Start) begin
        size_q <= ifmap_size;
        col    <= '0;
      end
      if (gb_rd_en) col <= issue_last ? '0 : col + 1'b1;
      if (in_flight) last_mem[wr_ptr] <= fl_last;
    end
  end
`else
  assign row_last = 1'b0;
`endif

endmodule

// File: tb/tb_ifmap_stream_feeder.sv
// Directed bench for ifmap_stream_feeder: address/data order, backpressure, wrap, empty job, abort, row_last.
module tb_ifmap_stream_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [9:0]  base_addr;
  logic [3:0]  ifmap_size;
  logic [1:0]  row_count;
  logic        gb_rd_en;
  logic [9:0]  gb_addr;
  logic [15:0] gb_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        row_last;
  logic        Done;

  ifmap_stream_feeder dut (
    .clk(clk), .rst(rst), .Start(Start), .base_addr(base_addr),
    .ifmap_size(ifmap_size), .row_count(row_count), .gb_rd_en(gb_rd_en),
    .gb_addr(gb_addr), .gb_rdata(gb_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .row_last(row_last), .Done(Done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [9:0] a);
    return {6'h2D, a};
  endfunction

  // Global buffer model: data one cycle after the read strobe.
  always @(posedge clk) if (gb_rd_en) gb_rdata <= word_of(gb_addr);

  int n_vec = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, done_cyc = -1, last_xfer_cyc = -1, first_v_cyc = -1, done_cnt = 0;
  logic [9:0]  addr_q [$];
  logic [15:0] data_q [$];
  logic        rl_q [$];
  logic        stall_prev = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (gb_rd_en) addr_q.push_back(gb_addr);
    if (out_valid && out_ready) begin
      data_q.push_back(out_data);
      rl_q.push_back(row_last);
      last_xfer_cyc = cyc;
    end
    if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
    if (Done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_valid_low", {31'b0, out_valid}, 0);
    end
    if (stall_prev && !rst) begin
      chk("stall_hold_valid", {31'b0, out_valid}, 1);
      chk("stall_hold_data", {16'b0, out_data}, {16'b0, prev_data});
    end
    stall_prev = out_valid && !out_ready && !rst;
    prev_data  = out_data;
  end

  task automatic clear();
    addr_q.delete(); data_q.delete(); rl_q.delete();
    done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1; first_v_cyc = -1;
  endtask

  task automatic start_job(input logic [9:0] b, input logic [3:0] s, input logic [1:0] r);
    base_addr = b; ifmap_size = s; row_count = r;
    Start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready toggles, plus a 5-cycle stall
  task automatic wait_done(input int budget, input int mode);
    for (int i = 0; i < budget; i++) begin
      if (mode == 0) out_ready = 1'b1;
      else out_ready = (i >= 12 && i < 17) ? 1'b0 : (i % 2 == 0);
      @(posedge clk); #1;
      if (done_cnt != 0) break;
    end
    out_ready = 1'b1;
    chk("done_seen", done_cnt, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic verify(input logic [9:0] b, input int n);
    logic [9:0] a;
    chk("n_reads", addr_q.size(), n);
    chk("n_words", data_q.size(), n);
    for (int i = 0; i < n; i++) begin
      a = b + 10'(i);
      if (i < addr_q.size()) chk("rd_addr", {22'b0, addr_q[i]}, {22'b0, a});
      if (i < data_q.size()) chk("out_word", {16'b0, data_q[i]}, {16'b0, word_of(a)});
    end
  endtask

  initial begin
    bit pulsed;
    rst = 1'b1; Start = 1'b0; base_addr = '0; ifmap_size = '0; row_count = '0; out_ready = 1'b1;
    idle(3);
    chk("rst_rd_en", {31'b0, gb_rd_en}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_done", {31'b0, Done}, 0);
    chk("rst_addr", {22'b0, gb_addr}, 0);
    chk("rst_data", {16'b0, out_data}, 0);
    chk("rst_row_last", {31'b0, row_last}, 0);
    rst = 1'b0;
    idle(2);

    // 1: full-rate stream
    clear();
    start_job(10'd0, 4'd10, 2'd3);
    wait_done(200, 0);
    idle(5);
    verify(10'd0, 30);
    chk("t1_first_valid", first_v_cyc, start_cyc + 3);
    chk("t1_done_timing", done_cyc, last_xfer_cyc + 1);
    chk("t1_done_count", done_cnt, 1);

    // 2: backpressure
    clear();
    start_job(10'd0, 4'd10, 2'd3);
    wait_done(400, 1);
    idle(5);
    verify(10'd0, 30);
    chk("t2_done_timing", done_cyc, last_xfer_cyc + 1);

    // 3: address wrap
    clear();
    start_job(10'd1020, 4'd8, 2'd1);
    wait_done(100, 0);
    idle(3);
    verify(10'd1020, 8);

    // 4: empty job
    clear();
    start_job(10'd7, 4'd0, 2'd3);
    wait_done(20, 0);
    idle(3);
    chk("t4_no_reads", addr_q.size(), 0);
    chk("t4_done_timing", done_cyc, start_cyc + 1);
    chk("t4_done_count", done_cnt, 1);

    // 5: Start ignored mid-stream, then reset abort after word 12
    clear();
    pulsed = 1'b0;
    start_job(10'd0, 4'd10, 2'd3);
    for (int i = 0; i < 100 && data_q.size() < 13; i++) begin
      if (data_q.size() >= 5 && !pulsed) begin
        Start = 1'b1; base_addr = 10'd500; ifmap_size = 4'd2; row_count = 2'd1; pulsed = 1'b1;
      end else Start = 1'b0;
      @(posedge clk); #1;
    end
    Start = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_rd_en", {31'b0, gb_rd_en}, 0);
    chk("abort_valid", {31'b0, out_valid}, 0);
    chk("abort_addr", {22'b0, gb_addr}, 0);
    chk("abort_data", {16'b0, out_data}, 0);
    chk("abort_done", {31'b0, Done}, 0);
    idle(2);
    rst = 1'b0;
    idle(5);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_words", data_q.size(), 13);
    for (int i = 0; i < 13 && i < data_q.size(); i++)
      chk("abort_word", {16'b0, data_q[i]}, {16'b0, word_of(10'(i))});
    clear();
    start_job(10'd100, 4'd4, 2'd1);
    wait_done(100, 0);
    idle(3);
    verify(10'd100, 4);

    // 6: row_last marking
    clear();
    start_job(10'd0, 4'd5, 2'd2);
    wait_done(100, 1);
    idle(3);
    verify(10'd0, 10);
    for (int i = 0; i < rl_q.size(); i++) begin
`ifdef IFMAP_FEEDER_ROW_LAST_EN
      chk("row_last", {31'b0, rl_q[i]}, {31'b0, (i == 4 || i == 9)});
`else
      chk("row_last", {31'b0, rl_q[i]}, 0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
